// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage operand, write-back and hold signals of the hazard scoreboard
interface hazard_scoreboard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int LAT_W      = 4,
   parameter int PERF_W     = 32
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic                  id_is_branch;
   logic                  id_wr_en;
   logic [REG_ADDR_W-1:0] id_rd;
   logic [LAT_W-1:0]      id_lat;
   logic                  wb_done;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  flush;
   logic                  pc_hold;
   logic                  ifid_hold;
   logic                  ctrl_hold;
   logic [PERF_W-1:0]     perf_hold_cycles;
   logic [PERF_W-1:0]     perf_hold_events;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_branch,
             id_wr_en, id_rd, id_lat, wb_done, wb_rd, flush,
      input  pc_hold, ifid_hold, ctrl_hold, perf_hold_cycles, perf_hold_events
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_is_branch,
             id_wr_en, id_rd, id_lat, wb_done, wb_rd, flush,
      output pc_hold, ifid_hold, ctrl_hold, perf_hold_cycles, perf_hold_events
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard generating ID-stage pipeline holds
// Optional stall counters enabled by HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int MAX_LAT    = 15,
   parameter int LAT_W      = $clog2(MAX_LAT + 1),
   parameter int PERF_W     = 32
) (
   input logic               clk,
   input logic               rst,
   hazard_scoreboard_if.slave sb
);
   localparam int NREG = 2 ** REG_ADDR_W;
   localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

   logic [LAT_W-1:0] cnt [NREG];
   logic [LAT_W-1:0] rs1_cnt;
   logic [LAT_W-1:0] rs2_cnt;
   logic [LAT_W-1:0] lat_sat;
   logic             need_rs1;
   logic             need_rs2;
   logic             hazard;
   logic             issue;

   assign rs1_cnt = cnt[sb.id_rs1];
   assign rs2_cnt = cnt[sb.id_rs2];

   // A branch compares in ID, so it needs the value one cycle earlier than an EX consumer.
   always_comb begin
      need_rs1 = 1'b0;
      need_rs2 = 1'b0;
      if (sb.id_rs1_used && sb.id_rs1 != '0)
         need_rs1 = sb.id_is_branch ? (rs1_cnt != '0) : (rs1_cnt > LAT_W'(1));
      if (sb.id_rs2_used && sb.id_rs2 != '0)
         need_rs2 = sb.id_is_branch ? (rs2_cnt != '0) : (rs2_cnt > LAT_W'(1));
   end

   assign hazard  = sb.id_valid && !sb.flush && (need_rs1 || need_rs2);
   assign issue   = sb.id_valid && !sb.flush && !hazard && sb.id_wr_en && (sb.id_rd != '0);
   assign lat_sat = (sb.id_lat > MAX_LAT_V) ? MAX_LAT_V : sb.id_lat;

   assign sb.pc_hold   = hazard;
   assign sb.ifid_hold = hazard;
   assign sb.ctrl_hold = hazard;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++)
            cnt[r] <= '0;
      end else begin
         cnt[0] <= '0;
         for (int r = 1; r < NREG; r++) begin
            if (issue && sb.id_rd == REG_ADDR_W'(r))
               cnt[r] <= lat_sat;
            else if (sb.wb_done && sb.wb_rd == REG_ADDR_W'(r))
               cnt[r] <= '0;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - LAT_W'(1);
         end
      end
   end

`ifdef HAZARD_SCOREBOARD_PERF_EN
   logic [PERF_W-1:0] hold_cycles;
   logic [PERF_W-1:0] hold_events;
   logic              hazard_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cycles <= '0;
         hold_events <= '0;
         hazard_q    <= 1'b0;
      end else begin
         hazard_q <= hazard;
         if (hazard && hold_cycles != '1)
            hold_cycles <= hold_cycles + PERF_W'(1);
         if (hazard && !hazard_q && hold_events != '1)
            hold_events <= hold_events + PERF_W'(1);
      end
   end

   assign sb.perf_hold_cycles = hold_cycles;
   assign sb.perf_hold_events = hold_events;
`else
   assign sb.perf_hold_cycles = '0;
   assign sb.perf_hold_events = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard with reference countdown model
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   bit   exp_q[$];
   int   m_cnt[32];
   longint m_hc = 0;
   longint m_he = 0;
   bit   m_prev = 1'b0;

   hazard_scoreboard_if #(.REG_ADDR_W(5), .LAT_W(4), .PERF_W(32)) sb ();

   hazard_scoreboard #(.REG_ADDR_W(5), .MAX_LAT(15), .PERF_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint exp_perf(input longint v);
`ifdef HAZARD_SCOREBOARD_PERF_EN
      return v;
`else
      return 0;
`endif
   endfunction

   function automatic bit m_need(input int rs, input bit used, input bit br);
      return used && rs != 0 && m_cnt[rs] > (br ? 0 : 1);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_hc = 0;
      m_he = 0;
      m_prev = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic drive_cycle(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                              input bit br, input bit wr, input int rd, input int lat,
                              input bit wbd, input int wbrd, input bit fl, output bit haz);
      bit exp_h;
      sb.id_valid     = v;
      sb.id_rs1       = 5'(rs1);
      sb.id_rs1_used  = u1;
      sb.id_rs2       = 5'(rs2);
      sb.id_rs2_used  = u2;
      sb.id_is_branch = br;
      sb.id_wr_en     = wr;
      sb.id_rd        = 5'(rd);
      sb.id_lat       = 4'(lat);
      sb.wb_done      = wbd;
      sb.wb_rd        = 5'(wbrd);
      sb.flush        = fl;
      haz = v && !fl && (m_need(rs1, u1, br) || m_need(rs2, u2, br));
      exp_q.push_back(haz);
      @(negedge clk);
      exp_h = exp_q.pop_front();
      check("hold", {sb.pc_hold, sb.ifid_hold, sb.ctrl_hold}, exp_h ? 7 : 0);
      check("perf_cycles", sb.perf_hold_cycles, exp_perf(m_hc));
      check("perf_events", sb.perf_hold_events, exp_perf(m_he));
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
      if (wbd) m_cnt[wbrd] = 0;
      if (v && !fl && !haz && wr && rd != 0) m_cnt[rd] = (lat > 15) ? 15 : lat;
      m_cnt[0] = 0;
      if (haz) m_hc++;
      if (haz && !m_prev) m_he++;
      m_prev = haz;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bit h;
      for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, h);
   endtask

   task automatic issue_op(input int rd, input int lat);
      bit h;
      drive_cycle(1, 0, 0, 0, 0, 0, 1, rd, lat, 0, 0, 0, h);
   endtask

   // Holds the consumer in ID until it issues; wb_done pulses on loop iteration wb_at.
   task automatic consume(input int rs1, input bit u1, input int rs2, input bit u2, input bit br,
                          input bit wr, input int rd, input int lat, input bit fl,
                          input int wb_at, input int wbrd, output int stalls);
      bit h;
      stalls = 0;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1, rs1, u1, rs2, u2, br, wr, rd, lat, i == wb_at, wbrd, fl, h);
         if (!h) break;
         stalls++;
      end
      if (stalls >= 40) check("stall_bound", stalls, 0);
   endtask

   initial begin
      int st;
      bit h;
      model_reset();
      sb.id_valid = 1'b1; sb.id_rs1 = 5'd5; sb.id_rs1_used = 1'b1;
      sb.id_rs2 = 5'd0; sb.id_rs2_used = 1'b0; sb.id_is_branch = 1'b0;
      sb.id_wr_en = 1'b0; sb.id_rd = 5'd0; sb.id_lat = 4'd0;
      sb.wb_done = 1'b0; sb.wb_rd = 5'd0; sb.flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_hold", {sb.pc_hold, sb.ifid_hold, sb.ctrl_hold}, 0);
      check("reset_perf_cycles", sb.perf_hold_cycles, 0);
      check("reset_perf_events", sb.perf_hold_events, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // load x5; add x6,x5,x1
      issue_op(5, 2);
      consume(5, 1, 1, 1, 0, 1, 6, 1, 0, -1, 0, st);
      check("load_use_stall", st, 1);
      check("load_use_perf_cycles", sb.perf_hold_cycles, exp_perf(1));
      check("load_use_perf_events", sb.perf_hold_events, exp_perf(1));
      idle(3);

      issue_op(5, 2);
      consume(5, 1, 0, 1, 1, 0, 0, 0, 0, -1, 0, st);
      check("branch_stall", st, 2);
      issue_op(5, 2);
      issue_op(12, 1);
      consume(5, 1, 0, 1, 1, 0, 0, 0, 0, -1, 0, st);
      check("branch_gap_stall", st, 1);
      idle(2);

      issue_op(7, 15);
      consume(7, 1, 0, 0, 0, 1, 13, 1, 0, 3, 7, st);
      check("early_wb_stall", st, 4);

      issue_op(0, 15);
      consume(0, 1, 0, 1, 0, 1, 14, 1, 0, -1, 0, st);
      check("x0_stall", st, 0);

      drive_cycle(1, 0, 0, 0, 0, 0, 1, 9, 3, 1, 9, 0, h);
      consume(9, 1, 0, 0, 0, 0, 0, 0, 0, -1, 0, st);
      check("issue_vs_wb_stall", st, 2);

      issue_op(11, 0);
      consume(11, 1, 0, 0, 1, 0, 0, 0, 0, -1, 0, st);
      check("lat0_stall", st, 0);
      idle(4);

      issue_op(5, 4);
      consume(5, 1, 0, 0, 0, 1, 10, 15, 1, -1, 0, st);
      check("flush_hold", st, 0);
      consume(5, 1, 0, 0, 0, 0, 0, 0, 0, -1, 0, st);
      check("after_flush_stall", st, 2);
      consume(10, 1, 0, 0, 0, 0, 0, 0, 0, -1, 0, st);
      check("flush_no_issue", st, 0);

      for (int k = 0; k < 60; k++) begin
         consume($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 15),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0) ? 0 : -1,
                 $urandom_range(0, 7), st);
      end
      idle(16);

      // Asynchronous reset in the middle of a mul stall
      issue_op(8, 10);
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, h);
         check("mul_stalling", h, 1);
      end
      #2 rst = 1'b1;
      #1;
      check("async_rst_hold", {sb.pc_hold, sb.ifid_hold, sb.ctrl_hold}, 0);
      check("async_rst_perf_cycles", sb.perf_hold_cycles, 0);
      check("async_rst_perf_events", sb.perf_hold_events, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      consume(8, 1, 0, 0, 0, 0, 0, 0, 0, -1, 0, st);
      check("post_rst_stall", st, 0);
      check("post_rst_perf_cycles", sb.perf_hold_cycles, 0);
      check("post_rst_perf_events", sb.perf_hold_events, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
